text_buffer: RTL and testbench

Character-cell text store and fetch stage that sits directly upstream of the character generator. It holds an 80×40 grid of 7-bit character codes, accepts host commands over a valid/ready port, and tracks a cursor. From the VGA counters it drives the character code to the font memory address, plus the glyph row index, pipelined so both are aligned with the pixel currently addressed by the counters.

---
 rtl/text_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_text_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer.sv
// ---------------------------------------------------------------------------
// text_buffer
//   Stores an 80x40 grid of 7-bit character codes and fetches the code and
//   glyph line for the pixel currently addressed by the VGA counters. The
//   fetch pipeline has two stages. It looks two pixels ahead so that its
//   outputs line up with the live counters. Host commands arrive on a
//   valid/ready port and move a wrapping cursor. After reset the block runs
//   a full clear before it accepts any command.
//
// Ports
//   clock25, reset_n            pixel clock, async active-low reset
//   HorizontalCounter[9:0]      current pixel column (0..799)
//   VerticalCounter[9:0]        current pixel line   (0..524)
//   cmd_valid / cmd_ready       host command handshake
//   cmd_op[1:0]                 0 WRITE, 1 SETCUR, 2 CLEAR, 3 NEWLINE
//   cmd_data[12:0]              WRITE: [6:0] code; SETCUR: [12:6] col, [5:0] row
//   address[6:0]                character code for the font memory
//   glyph_row[3:0]              line within the 12-line glyph
//   cursor_col[6:0], cursor_row[5:0]  current cursor position
//   busy                        clear in progress
// ---------------------------------------------------------------------------
module text_buffer (
    input  logic        clock25,
    input  logic        reset_n,
    input  logic [9:0]  HorizontalCounter,
    input  logic [9:0]  VerticalCounter,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [12:0] cmd_data,
    output logic [6:0]  address,
    output logic [3:0]  glyph_row,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);
    localparam logic [9:0]  H_TOTAL  = 10'd800;
    localparam logic [9:0]  V_TOTAL  = 10'd525;
    localparam logic [6:0]  COLS     = 7'd80;
    localparam logic [5:0]  ROWS     = 6'd40;
    localparam logic [6:0]  BLANK    = 7'd32;
    localparam logic [11:0] LAST_IDX = 12'd3199;

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_SETCUR  = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;
    localparam logic [1:0] OP_NEWLINE = 2'd3;

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    // ------------------------------------------------------------------
    // Fetch lookahead: (h+2, v) with wrap across line and frame ends
    // ------------------------------------------------------------------
    logic [10:0] h_sum;
    logic [9:0]  h_la;
    logic [9:0]  v_la;
    logic [39:1] row_ge;
    logic [5:0]  row_div;
    logic [9:0]  row_base;
    logic [6:0]  col_la;
    logic        vis_la;
    logic [11:0] fetch_idx_d;
    logic [3:0]  fetch_row_d;

    always_comb begin
        h_sum = {1'b0, HorizontalCounter} + 11'd2;
        if (h_sum >= {1'b0, H_TOTAL}) begin
            h_la = 10'(h_sum - {1'b0, H_TOTAL});
            v_la = (VerticalCounter == V_TOTAL - 10'd1) ? 10'd0 : VerticalCounter + 10'd1;
        end else begin
            h_la = h_sum[9:0];
            v_la = VerticalCounter;
        end
    end

    // v/12 without a divider: one constant comparator per row boundary,
    // the highest boundary passed gives the text row.
    genvar gi;
    generate
        for (gi = 1; gi < 40; gi++) begin : g_row_cmp
            assign row_ge[gi] = (v_la >= 10'(gi * 12));
        end
    endgenerate

    always_comb begin
        row_div  = 6'd0;
        row_base = 10'd0;
        for (int k = 1; k < 40; k++) begin
            if (row_ge[k]) begin
                row_div  = 6'(k);
                row_base = 10'(k * 12);
            end
        end
        col_la = h_la[9:3];
        vis_la = (h_la < 10'd640) && (v_la < 10'd480);
        // row*80 = row*64 + row*16; forced to 0 off-screen to stay in range
        fetch_idx_d = vis_la ? ({row_div, 6'b0} + {2'b0, row_div, 4'b0} + {5'b0, col_la}) : 12'd0;
        fetch_row_d = vis_la ? 4'(v_la - row_base) : 4'd0;
    end

    // ------------------------------------------------------------------
    // Command FSM and cursor
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [11:0] clr_idx_q, clr_idx_d;
    logic [6:0]  cur_col_q, cur_col_d;
    logic [5:0]  cur_row_q, cur_row_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        wr_en;
    logic [11:0] wr_idx;
    logic [6:0]  wr_data;
    logic [11:0] cursor_idx;

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        cur_col_d   = cur_col_q;
        cur_row_d   = cur_row_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        wr_en       = 1'b0;
        wr_idx      = clr_idx_q;
        wr_data     = BLANK;
        cursor_idx  = {cur_row_q, 6'b0} + {2'b0, cur_row_q, 4'b0} + {5'b0, cur_col_q};

        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                clr_idx_d = clr_idx_q + 12'd1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    cur_col_d   = 7'd0;
                    cur_row_d   = 6'd0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_en   = 1'b1;
                            wr_idx  = cursor_idx;
                            wr_data = cmd_data[6:0];
                            if (cur_col_q == COLS - 7'd1) begin
                                cur_col_d = 7'd0;
                                cur_row_d = (cur_row_q == ROWS - 6'd1) ? 6'd0 : cur_row_q + 6'd1;
                            end else begin
                                cur_col_d = cur_col_q + 7'd1;
                            end
                        end
                        OP_SETCUR: begin
                            // Out-of-range targets are accepted but dropped.
                            if (cmd_data[12:6] < COLS && cmd_data[5:0] < ROWS) begin
                                cur_col_d = cmd_data[12:6];
                                cur_row_d = cmd_data[5:0];
                            end
                        end
                        OP_CLEAR: begin
                            clr_idx_d   = 12'd0;
                            state_d     = ST_CLEAR;
                            cmd_ready_d = 1'b0;
                            busy_d      = 1'b1;
                        end
                        OP_NEWLINE: begin
                            cur_col_d = 7'd0;
                            cur_row_d = (cur_row_q == ROWS - 6'd1) ? 6'd0 : cur_row_q + 6'd1;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Character RAM: one write port and a registered read port. The read
    // takes the pre-write contents when both hit the same cell.
    // ------------------------------------------------------------------
    logic [6:0]  mem [0:3199];
    logic [6:0]  rd_data_q;
    logic [11:0] fetch_idx_q;
    logic [3:0]  fetch_row_q;
    logic        fetch_vis_q;
    logic        out_vis_q;
    logic [3:0]  glyph_row_q;

    always_ff @(posedge clock25) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data_q <= mem[fetch_idx_q];
    end

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= 12'd0;
            cur_col_q   <= 7'd0;
            cur_row_q   <= 6'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            fetch_idx_q <= 12'd0;
            fetch_row_q <= 4'd0;
            fetch_vis_q <= 1'b0;
            out_vis_q   <= 1'b0;
            glyph_row_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cur_col_q   <= cur_col_d;
            cur_row_q   <= cur_row_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            fetch_idx_q <= fetch_idx_d;
            fetch_row_q <= fetch_row_d;
            fetch_vis_q <= vis_la;
            out_vis_q   <= fetch_vis_q;
            glyph_row_q <= fetch_vis_q ? fetch_row_q : 4'd0;
        end
    end

    // The RAM output register has no reset, so the visibility flag (which
    // does) selects BLANK for off-screen pixels and right after reset.
    assign address    = out_vis_q ? rd_data_q : BLANK;
    assign glyph_row  = glyph_row_q;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign cursor_col = cur_col_q;
    assign cursor_row = cur_row_q;

endmodule

// File: tb/tb_text_buffer.sv
module tb_text_buffer;
    logic        clock25 = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [12:0] cmd_data = '0;
    logic        cmd_ready;
    logic [6:0]  address;
    logic [3:0]  glyph_row;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    text_buffer dut (
        .clock25           (clock25),
        .reset_n           (reset_n),
        .HorizontalCounter (hc),
        .VerticalCounter   (vc),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_data          (cmd_data),
        .address           (address),
        .glyph_row         (glyph_row),
        .cursor_col        (cursor_col),
        .cursor_row        (cursor_row),
        .busy              (busy)
    );

    always #20 clock25 = ~clock25;

    // Reference model: screen contents as a flat array, cursor as integers.
    int m_mem [0:3199];
    int m_col, m_row;
    int clear_left;     // edges until the model expects the clear to finish
    int cyc;
    int last_mem;       // edge of the last content change
    int run_len;        // edges since the counters last jumped
    int h_cnt, v_cnt;
    bit in_reset;
    bit accepted;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d cyc=%0d)", tag, got, exp, h_cnt, v_cnt, cyc);
        end
    endtask

    function automatic int exp_addr(input int h, input int v);
        if (h < 640 && v < 480) return m_mem[(v / 12) * 80 + h / 8];
        return 32;
    endfunction

    function automatic int exp_glyph(input int h, input int v);
        if (h < 640 && v < 480) return v % 12;
        return 0;
    endfunction

    task automatic fill_blank();
        for (int i = 0; i < 3200; i++) m_mem[i] = 32;
    endtask

    task automatic jump(input int h, input int v);
        h_cnt = h; v_cnt = v;
        hc = 10'(h); vc = 10'(v);
        run_len = 0;
    endtask

    // One clock: apply any accepted command to the model, advance the
    // counters, then compare every output with the model.
    task automatic tick();
        bit acc;
        acc = cmd_valid && (clear_left == 0) && !in_reset;
        @(posedge clock25);
        cyc++;
        #1;
        if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                m_col = 0; m_row = 0; last_mem = cyc;
            end
        end
        if (acc) begin
            case (cmd_op)
                2'd0: begin
                    m_mem[m_row * 80 + m_col] = int'(cmd_data[6:0]);
                    last_mem = cyc;
                    m_col++;
                    if (m_col == 80) begin m_col = 0; m_row = (m_row + 1) % 40; end
                end
                2'd1: if (cmd_data[12:6] < 80 && cmd_data[5:0] < 40) begin
                    m_col = int'(cmd_data[12:6]); m_row = int'(cmd_data[5:0]);
                end
                2'd2: begin clear_left = 3200; fill_blank(); last_mem = cyc; end
                default: begin m_col = 0; m_row = (m_row + 1) % 40; end
            endcase
            $display("cmd op=%0d data=%h accepted at cyc %0d, cursor %0d/%0d", cmd_op, cmd_data, cyc, m_col, m_row);
            accepted = 1'b1;
            cmd_valid = 1'b0;
        end
        h_cnt++;
        if (h_cnt == 800) begin
            h_cnt = 0; v_cnt++;
            if (v_cnt == 525) v_cnt = 0;
        end
        hc = 10'(h_cnt); vc = 10'(v_cnt);
        run_len++;
        if (!in_reset) begin
            check_eq("cmd_ready", cmd_ready, clear_left == 0);
            check_eq("busy", busy, clear_left != 0);
            check_eq("cursor_col", cursor_col, m_col);
            check_eq("cursor_row", cursor_row, m_row);
            if (clear_left == 0 && run_len >= 2 && cyc - last_mem >= 2) begin
                check_eq("address", address, exp_addr(h_cnt, v_cnt));
                check_eq("glyph_row", glyph_row, exp_glyph(h_cnt, v_cnt));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] op, input logic [12:0] data);
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1; accepted = 1'b0;
        for (int i = 0; i < 4000 && !accepted; i++) tick();
        if (!accepted) begin
            check_eq("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        reset_n = 1'b0;
        ticks(3);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_address", address, 32);
        check_eq("rst_glyph_row", glyph_row, 0);
        check_eq("rst_cursor_col", cursor_col, 0);
        check_eq("rst_cursor_row", cursor_row, 0);
        reset_n = 1'b1;
        in_reset = 1'b0;
        clear_left = 3200;
        m_col = 0; m_row = 0;
        fill_blank();
        last_mem = cyc;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3300 && clear_left != 0; i++) tick();
        ticks(2);
    endtask

    // Visit every cell once with a short run so each is compared.
    task automatic scan_all();
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < 80; c++) begin
                jump(c * 8 + int'($urandom_range(0, 5)), r * 12 + int'($urandom_range(0, 11)));
                ticks(3);
            end
        end
    endtask

    initial begin
        cyc = 0; last_mem = 0; run_len = 0; h_cnt = 0; v_cnt = 0;
        m_col = 0; m_row = 0; clear_left = 0; in_reset = 1'b1;
        fill_blank();

        // Reset, automatic clear, blank screen everywhere
        do_reset();
        wait_idle();
        scan_all();
        jump(630, 470); ticks(200);

        // Single character at col 5, row 2 and its neighbours
        send(2'd1, 13'((5 << 6) | 2));
        send(2'd0, 13'h41);
        for (int i = 0; i < 12; i++) begin
            jump(36, 24 + i); ticks(16);
        end

        // Write at the last cell, then wrap to (0,0)
        send(2'd1, 13'((79 << 6) | 39));
        send(2'd0, 13'h42);
        send(2'd0, 13'h43);
        jump(628, 468); ticks(14);
        jump(794, 524); ticks(14);

        // Out-of-range SETCUR ignored; NEWLINE wraps the row
        send(2'd1, 13'((80 << 6) | 3));
        send(2'd1, 13'((10 << 6) | 40));
        send(2'd1, 13'((17 << 6) | 39));
        send(2'd3, 13'd0);

        // Line and frame wrap of the lookahead, blanking region
        send(2'd0, 13'h55);
        send(2'd1, 13'((0 << 6) | 1));
        send(2'd0, 13'h66);
        jump(790, 11); ticks(20);
        jump(630, 200); ticks(185);
        jump(795, 524); ticks(12);

        // Randomized commands interleaved with counter runs
        for (int n = 0; n < 160; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5) begin
                send(2'd0, 13'($urandom_range(0, 127)));
            end else if (sel == 6) begin
                send(2'd1, 13'(($urandom_range(0, 90) << 6) | $urandom_range(0, 45)));
            end else if (sel == 7) begin
                send(2'd3, 13'($urandom));
            end else begin
                jump(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
                ticks(int'($urandom_range(3, 30)));
            end
        end
        for (int n = 0; n < 600; n++) begin
            jump(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            ticks(3);
        end

        // CLEAR with content present; commands offered while busy are ignored
        send(2'd2, 13'd0);
        cmd_op = 2'd0; cmd_data = 13'h7F; cmd_valid = 1'b1;
        ticks(100);
        cmd_valid = 1'b0;
        wait_idle();
        scan_all();

        // Reset in the middle of a clear restarts it
        send(2'd1, 13'((7 << 6) | 7));
        send(2'd0, 13'h31);
        send(2'd2, 13'd0);
        ticks(1000);
        do_reset();
        wait_idle();
        jump(0, 0); ticks(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
